// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the data memory. One store drains per cycle when no load uses the port.
// Macro STBUF_FWD_EN enables word store-to-load forwarding from the youngest matching entry.
module store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   StoreEn,
  input  logic                   LoadEn,
  input  logic                   Fence,
  input  logic [1:0]             WidthSrcIn,
  input  logic [WIDTH-1:0]       AIn,
  input  logic [WIDTH-1:0]       WDIn,
  output logic                   MemWE,
  output logic [1:0]             MemWidthSrc,
  output logic [WIDTH-1:0]       MemA,
  output logic [WIDTH-1:0]       MemWD,
  output logic                   Stall,
  output logic                   LoadFwdValid,
  output logic [WIDTH-1:0]       LoadFwdData,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] a_q  [DEPTH];
  logic [WIDTH-1:0] wd_q [DEPTH];
  logic [1:0]       ws_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic          hit;
  logic          fwd;
  logic          load_conflict;
  logic          drain;
  logic          enqueue;
  logic          full;
  logic [PW-1:0] idx;
`ifdef STBUF_FWD_EN
  logic [PW-1:0] hit_idx;
`endif

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STBUF_FWD_EN
    hit_idx = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (a_q[idx][WIDTH-1:2] == AIn[WIDTH-1:2])) begin
        hit = 1'b1;
`ifdef STBUF_FWD_EN
        hit_idx = idx;
`endif
      end
    end
  end

  always_comb begin
`ifdef STBUF_FWD_EN
    fwd          = LoadEn & (WidthSrcIn == 2'b00) & hit & (ws_q[hit_idx] == 2'b00);
    LoadFwdData  = fwd ? wd_q[hit_idx] : '0;
`else
    fwd          = 1'b0;
    LoadFwdData  = '0;
`endif
    LoadFwdValid  = fwd;
    full          = (count_q == CW'(DEPTH));
    load_conflict = LoadEn & hit & ~fwd;
    drain         = (count_q != '0) & (~LoadEn | load_conflict);
    enqueue       = StoreEn & ~LoadEn & (~full | drain);
    Stall         = (StoreEn & full & ~drain) | load_conflict
                  | (Fence & (count_q != '0)) | (StoreEn & LoadEn);
    Empty         = (count_q == '0);
    Count         = count_q;

    // The port serves the load whenever the head is not being written.
    MemWE       = drain;
    MemWD       = wd_q[head_q];
    MemA        = drain ? a_q[head_q]  : AIn;
    MemWidthSrc = drain ? ws_q[head_q] : WidthSrcIn;
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Clear before set: a full buffer can pop and push the same slot.
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (enqueue) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (enqueue && !drain) begin
      count_d = count_q + CW'(1);
    end else if (drain && !enqueue) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i]  <= '0;
        wd_q[i] <= '0;
        ws_q[i] <= '0;
      end
    end else if (enqueue) begin
      a_q[tail_q]  <= AIn;
      wd_q[tail_q] <= WDIn;
      ws_q[tail_q] <= WidthSrcIn;
    end
  end

endmodule
